// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

    localparam int OFF_W      = 5;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILLED  = 2'd3
    } state_e;

    // Line-aligned byte address built from a tag and an index (offset bits zero).
    function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                              input logic [31:0] idx,
                                              input int          idx_w);
        return (tag << (OFF_W + idx_w)) | (idx << OFF_W);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/data storage for the data cache: one {valid, dirty, tag, data} entry per line.
// Reads are combinational at idx_i; writes are synchronous. A full-line write
// installs a clean valid line, a word write merges one word and marks it dirty.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter  int NUM_LINES = 32,
    parameter  int LINE_BITS = 256,
    parameter  int TAG_W     = 22,
    localparam int IDX_W     = $clog2(NUM_LINES),
    localparam int WSEL_W    = $clog2(LINE_BITS / WORD_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic                 valid_o,
    output logic                 dirty_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic [LINE_BITS-1:0] data_o,
    input  logic                 line_we_i,
    input  logic [TAG_W-1:0]     line_tag_i,
    input  logic [LINE_BITS-1:0] line_data_i,
    input  logic                 word_we_i,
    input  logic [WSEL_W-1:0]    word_sel_i,
    input  logic [WORD_W-1:0]    word_data_i
);

    logic                 valid_q [NUM_LINES];
    logic                 dirty_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q   [NUM_LINES];
    logic [LINE_BITS-1:0] data_q  [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Status bits: cleared on reset, fill installs clean, store marks dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data payload; no reset needed since valid gates every use.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][WORD_W*word_sel_i +: WORD_W] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; misses stall, write back a dirty victim,
// fill the line, then spend one REFILLED cycle before the request replays as a hit.
// Memory handshake: mem_enable_o with address/data is held stable until the
// single-cycle mem_ack_i pulse; ack is ignored outside WRITEBACK/ALLOCATE.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_memread_i,
    input  logic                 cpu_memwrite_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output state_e               dbg_state_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          stat_hits_o,
    output logic [31:0]          stat_misses_o
`endif
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;

    state_e state_q, state_d;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [WSEL_W-1:0]    req_word;
    logic                 req, is_write, hit;
    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 line_we, word_we;
    logic [1:0]           unused_byte_bits;

    assign req_tag          = cpu_addr_i[31 -: TAG_W];
    assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
    assign req_word         = cpu_addr_i[2 +: WSEL_W];
    assign unused_byte_bits = cpu_addr_i[1:0];

    // A simultaneous read and write request behaves as a write.
    assign req      = cpu_memread_i | cpu_memwrite_i;
    assign is_write = cpu_memwrite_i;
    assign hit      = req & rd_valid & (rd_tag == req_tag);

    assign cpu_data_o  = hit ? rd_data[WORD_W*req_word +: WORD_W] : '0;
    assign dbg_state_o = state_q;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (req_idx),
        .valid_o     (rd_valid),
        .dirty_o     (rd_dirty),
        .tag_o       (rd_tag),
        .data_o      (rd_data),
        .line_we_i   (line_we),
        .line_tag_i  (req_tag),
        .line_data_i (mem_data_i),
        .word_we_i   (word_we),
        .word_sel_i  (req_word),
        .word_data_i (cpu_data_i)
    );

    // State register; reset abandons any in-flight transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall, memory port and storage write enables.
    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        line_we      = 1'b0;
        word_we      = 1'b0;
        case (state_q)
            IDLE: begin
                word_we = is_write & hit;
                if (req && !hit) begin
                    cpu_stall_o = 1'b1;
                    state_d     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = line_addr(32'(rd_tag), 32'(req_idx), IDX_W);
                mem_data_o   = rd_data;
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = line_addr(32'(req_tag), 32'(req_idx), IDX_W);
                if (mem_ack_i) begin
                    line_we = 1'b1;
                    state_d = REFILLED;
                end
            end
            REFILLED: begin
                // The held request now hits; a store merges its word here.
                cpu_stall_o = 1'b1;
                word_we     = is_write & hit;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic after_refill_q;

    // Saturating counters: IDLE hits (not the replay after a refill) and miss starts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            after_refill_q <= 1'b0;
            stat_hits_o    <= '0;
            stat_misses_o  <= '0;
        end else begin
            after_refill_q <= (state_q == REFILLED);
            if (state_q == IDLE && hit && !after_refill_q && stat_hits_o != 32'hFFFF_FFFF)
                stat_hits_o <= stat_hits_o + 32'd1;
            if (state_q == IDLE && req && !hit && stat_misses_o != 32'hFFFF_FFFF)
                stat_misses_o <= stat_misses_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a line-level cache/memory model predicts, cycle by cycle,
// the stall, memory-port and load-data outputs for each access; directed accesses
// pin the model with literal values, then randomized conflicting traffic follows.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int NUM_LINES = 32;
    localparam int LINE_BITS = 256;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cpu_rd, cpu_wr;
    logic [31:0]          cpu_addr, cpu_wdata, cpu_rdata;
    logic                 stall, mem_en, mem_wr, mem_ack;
    logic [31:0]          mem_addr;
    logic [LINE_BITS-1:0] mem_wdata, mem_rdata;
    state_e               dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0]          stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_memread_i  (cpu_rd),
        .cpu_memwrite_i (cpu_wr),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (stall),
        .mem_enable_o   (mem_en),
        .mem_write_o    (mem_wr),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_data_i     (mem_rdata),
        .mem_ack_i      (mem_ack),
        .dbg_state_o    (dbg_state)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits_o    (stat_hits),
        .stat_misses_o  (stat_misses)
`endif
    );

    // ---------------- scoreboard counters and check ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    function void chk(string name, logic [255:0] act, logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // ---------------- behavioural model ----------------
    logic                 m_valid [NUM_LINES];
    logic                 m_dirty [NUM_LINES];
    logic [21:0]          m_tag   [NUM_LINES];
    logic [LINE_BITS-1:0] m_data  [NUM_LINES];
    logic [LINE_BITS-1:0] mem_m   [logic [31:0]];

    function logic [LINE_BITS-1:0] mem_line(logic [31:0] a);
        logic [LINE_BITS-1:0] l;
        if (mem_m.exists(a)) return mem_m[a];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a ^ (i * 32'h1111_0001) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function logic [LINE_BITS-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function void model_reset();
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    // ---------------- per-cycle expectations ----------------
    logic                 chk_on;
    logic                 exp_stall, exp_en, exp_write;
    logic [31:0]          exp_addr, exp_cpu;
    logic [LINE_BITS-1:0] exp_line;

    // observations recorded for the directed literal checks
    int                   wb_cyc = 0;
    logic [31:0]          cap_wb_addr, cap_fill_addr, cap_cpu;
    logic [LINE_BITS-1:0] cap_wb_data;

    task automatic set_exp(input logic s, input logic e, input logic w, input logic [31:0] a,
                           input logic [LINE_BITS-1:0] l, input logic [31:0] c);
        exp_stall = s; exp_en = e; exp_write = w; exp_addr = a; exp_line = l; exp_cpu = c;
    endtask

    // Compare process: sample on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cpu_stall", 256'(stall), 256'(exp_stall));
            chk("mem_enable", 256'(mem_en), 256'(exp_en));
            chk("cpu_data", 256'(cpu_rdata), 256'(exp_cpu));
            if (exp_en) begin
                chk("mem_write", 256'(mem_wr), 256'(exp_write));
                chk("mem_addr", 256'(mem_addr), 256'(exp_addr));
                if (exp_write) chk("mem_data", mem_wdata, exp_line);
            end
        end
        if (mem_en && mem_wr) begin
            wb_cyc++;
            cap_wb_addr = mem_addr;
            cap_wb_data = mem_wdata;
        end
        if (mem_en && !mem_wr) cap_fill_addr = mem_addr;
        if ((cpu_rd || cpu_wr) && !stall) cap_cpu = cpu_rdata;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit ack_noise);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        set_exp(0, 0, 0, '0, '0, '0);
        for (int i = 0; i < n; i++) begin
            mem_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = rand_line();
            tick();
        end
        mem_ack = 1'b0;
    endtask

    // One line transfer: lat cycles waiting, then the ack cycle.
    task automatic mem_xfer(input logic is_wb, input logic [31:0] a,
                            input logic [LINE_BITS-1:0] l, input int lat);
        for (int i = 0; i < lat; i++) begin
            set_exp(1, 1, is_wb, a, l, '0);
            mem_ack   = 1'b0;
            mem_rdata = rand_line();
            tick();
        end
        set_exp(1, 1, is_wb, a, l, '0);
        mem_ack   = 1'b1;
        mem_rdata = is_wb ? rand_line() : l;
        tick();
        mem_ack = 1'b0;
    endtask

    // One CPU access from issue to the cycle it completes without stall.
    task automatic access(input logic is_wr, input logic both, input logic [31:0] a,
                          input logic [31:0] wd, input int lat);
        logic [4:0]           idx;
        logic [21:0]          tag;
        int                   w;
        logic [31:0]          va, fa;
        logic [LINE_BITS-1:0] l;
        idx = a[9:5];
        tag = a[31:10];
        w   = int'(a[4:2]);
        cpu_rd    = !is_wr || both;
        cpu_wr    = is_wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            set_exp(1, 0, 0, '0, '0, '0);
            tick();
            if (m_valid[idx] && m_dirty[idx]) begin
                va = {m_tag[idx], idx, 5'b0};
                mem_xfer(1'b1, va, m_data[idx], lat);
                mem_m[va] = m_data[idx];
            end
            fa = {tag, idx, 5'b0};
            l  = mem_line(fa);
            mem_xfer(1'b0, fa, l, lat);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_data[idx]  = l;
            set_exp(1, 0, 0, '0, '0, m_data[idx][32*w +: 32]);
            tick();
            if (is_wr) begin
                m_data[idx][32*w +: 32] = wd;
                m_dirty[idx] = 1'b1;
            end
        end
        set_exp(0, 0, 0, '0, '0, m_data[idx][32*w +: 32]);
        tick();
        if (is_wr) begin
            m_data[idx][32*w +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int                   wb0;
        logic [LINE_BITS-1:0] l;
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; chk_on = 1'b0;
        set_exp(0, 0, 0, '0, '0, '0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk_on = 1'b1;

        // reset state of every output
        @(negedge clk);
        chk("rst_stall", 256'(stall), 256'(0));
        chk("rst_mem_enable", 256'(mem_en), 256'(0));
        chk("rst_mem_write", 256'(mem_wr), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("rst_mem_data", mem_wdata, '0);
        chk("rst_cpu_data", 256'(cpu_rdata), 256'(0));
        tick();

        // first load miss fills line 0x40 (word0 = DEADBEEF)
        l = mem_line(32'h40);
        l[31:0] = 32'hDEAD_BEEF;
        mem_m[32'h40] = l;
        wb0 = wb_cyc;
        access(0, 0, 32'h40, '0, 2);
        chk("fill_addr_40", 256'(cap_fill_addr), 256'(32'h40));
        chk("load_40", 256'(cap_cpu), 256'(32'hDEAD_BEEF));
        chk("no_wb_cold", 256'(wb_cyc - wb0), 256'(0));
        idle_cycles(1, 0);

        // store hit then load back
        access(1, 0, 32'h44, 32'h1234_5678, 0);
        idle_cycles(1, 0);
        access(0, 0, 32'h44, '0, 0);
        chk("load_44", 256'(cap_cpu), 256'(32'h1234_5678));
        idle_cycles(1, 0);

        // conflicting load evicts the dirty line
        wb0 = wb_cyc;
        access(0, 0, 32'h440, '0, 1);
        chk("evict_wb_seen", 256'(wb_cyc != wb0), 256'(1));
        chk("evict_wb_addr", 256'(cap_wb_addr), 256'(32'h40));
        chk("evict_wb_word1", 256'(cap_wb_data[63:32]), 256'(32'h1234_5678));
        chk("evict_fill_addr", 256'(cap_fill_addr), 256'(32'h440));
        idle_cycles(2, 0);

        // store miss on a clean line: allocate only, merge, later written back
        wb0 = wb_cyc;
        access(1, 0, 32'h80, 32'hCAFE_F00D, 1);
        chk("store_miss_no_wb", 256'(wb_cyc - wb0), 256'(0));
        chk("store_miss_fill", 256'(cap_fill_addr), 256'(32'h80));
        idle_cycles(1, 0);
        access(0, 0, 32'h480, '0, 0);
        chk("merged_wb_addr", 256'(cap_wb_addr), 256'(32'h80));
        chk("merged_wb_word0", 256'(cap_wb_data[31:0]), 256'(32'hCAFE_F00D));
        idle_cycles(1, 0);

        // slow memory: outputs held for 10 cycles; stray ack in IDLE ignored
        access(0, 0, 32'h100, '0, 10);
        idle_cycles(1, 0);
        cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b1; set_exp(0, 0, 0, '0, '0, '0);
        tick();
        mem_ack = 1'b0;
        wb0 = wb_cyc;
        access(0, 0, 32'h104, '0, 0);
        chk("stray_ack_no_mem", 256'(wb_cyc - wb0), 256'(0));
        idle_cycles(1, 0);

        // reset during a writeback
        access(1, 0, 32'h448, 32'h0BAD_CAFE, 0);
        idle_cycles(1, 0);
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h840;
        set_exp(1, 0, 0, '0, '0, '0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_exp(1, 1, 1, 32'h440, m_data[2], '0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_rd = 1'b0;
        model_reset();
        set_exp(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("rst_mid_wb_state", 256'(dbg_state), 256'(IDLE));
        chk("rst_mid_wb_enable", 256'(mem_en), 256'(0));
        tick();
        wb0 = wb_cyc;
        access(0, 0, 32'h440, '0, 1);
        chk("reload_no_wb", 256'(wb_cyc - wb0), 256'(0));
        chk("reload_fill_addr", 256'(cap_fill_addr), 256'(32'h440));
        idle_cycles(1, 0);

        // randomized conflicting traffic over 4 tags x 4 indices
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5)
              | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom(),
                   $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2), 1);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache placed between the MEM stage and the data memory.
- Serves word loads and stores in the same cycle on a hit.
- On a miss, stalls the pipeline and moves whole lines over a handshaked line-wide memory port: writeback of a dirty victim first, then the fill.

Parameters:
- NUM_LINES, 32, number of cache lines; power of two; index width IDX_W = log2(NUM_LINES).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width OFF_W = 5.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_memread_i  in  1  load request.
- cpu_memwrite_i  in  1  store request.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_stall_o=0.
- cpu_stall_o  out  1  freeze the pipeline while high.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = writeback, 0 = fill.
- mem_addr_o  out  32  line-aligned address; low OFF_W bits are 0.
- mem_data_o  out  LINE_BITS  writeback line.
- mem_data_i  in  LINE_BITS  fill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split: tag = addr[31:OFF_W+IDX_W], index = addr[OFF_W+IDX_W-1:OFF_W], word = addr[OFF_W-1:2].
- Storage per line: valid, dirty, tag, data.
- hit = req & valid[idx] & (tag[idx]==addr tag), where req = memread|memwrite. Both read and write high together is treated as a write.
- States: IDLE, WRITEBACK, ALLOCATE, REFILLED.
- IDLE:
  - hit: cpu_data_o = selected word (combinational); cpu_stall_o=0.
  - store hit: at posedge write cpu_data_i into the word and set dirty.
  - miss: cpu_stall_o=1 in the same cycle. Next state is WRITEBACK if the victim is valid&dirty, else ALLOCATE.
- WRITEBACK:
  - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, idx, 0}, mem_data_o=victim line.
  - Holds until mem_ack_i, then goes to ALLOCATE.
- ALLOCATE:
  - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, idx, 0}.
  - On mem_ack_i: load the line from mem_data_i, tag<=req tag, valid<=1, dirty<=0, then go to REFILLED.
- REFILLED:
  - cpu_stall_o=1 and memory idle for one cycle; then IDLE.
  - The request, held stable by the stall, now hits. A store completes there and sets dirty.
- Miss latency: 2 + memory cycles per transfer (+ writeback transfer if the victim is dirty).
- cpu_stall_o = (state!=IDLE) | (req & ~hit).
- mem_enable_o is held until ack; address and data stay stable while enable is high.
- mem_ack_i is ignored in IDLE and REFILLED.
- cpu_addr_i changing during a stall is a protocol violation; no checking.
- Reset (any state, including mid-transfer): state<=IDLE; all valid and dirty<=0.
  - Outputs after reset: cpu_stall_o=0 when no request, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0 when there is no hit.
  - An in-flight memory transaction is abandoned; memory must tolerate enable dropping.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs stat_hits_o[31:0] and stat_misses_o[31:0].
  - Hits count one per IDLE-cycle hit, excluding hits in the cycle right after REFILLED.
  - Misses count one per IDLE→WRITEBACK/ALLOCATE transition.
  - Both cleared by rst_i and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, ALLOCATE, REFILLED};
  - OFF_W = 5;
  - WORD_BYTES = 4;
  - helper function line_addr(tag, idx).
- One sub-module, dcache_sram:
  - NUM_LINES × {valid, dirty, tag, data} array;
  - combinational read at index, synchronous write with full-line and single-word write enables;
  - synchronous clear of valid/dirty on reset.

Test Plan:
- Reset, then load from 0x0000_0040 → stall=1. ALLOCATE with mem_addr_o=0x40, mem_write_o=0. Ack with line word0=0xDEADBEEF → after REFILLED, cpu_data_o=0xDEADBEEF, stall=0.
- Store 0x12345678 to 0x44 (hit) → no stall. A following load of 0x44 returns 0x12345678; the line is dirty.
- Load 0x0000_0440 (same index 2, different tag) → WRITEBACK first with mem_addr_o=0x40, mem_write_o=1, mem_data_o word1=0x12345678. Then ALLOCATE with mem_addr_o=0x440.
- Store miss to clean line 0x80 → ALLOCATE only, no WRITEBACK. After fill, the word is merged and the line is dirty; a later eviction writes it back.
- Hold mem_ack_i low 10 cycles in ALLOCATE → mem_enable_o, mem_addr_o and stall stay stable throughout. An ack pulse while IDLE has no effect.
- Assert rst_i during WRITEBACK → next cycle state IDLE, mem_enable_o=0. A reload of 0x440 misses (valid cleared).
